fifo_access_arbiter: RTL
========================

// Module: fifo_access_arbiter
// PURPOSE
//  Sequences all accesses to one shared coherence-request FIFO. Three requesters share it:
//   processor push, processor pop and snoop pop.
//  Emits single-cycle fifo_wr_en/fifo_rd_en pulses, waits the FIFO read latency and returns
//   popped data to the winning reader.
//  Sits between cache controller/snoop unit and FIFO; snoop pops have priority with bounded
//   processor starvation.
// PARAMETERS
//  DATA_W            4  FIFO entry width (bits)
//  READ_LAT          1  cycles from fifo_rd_en pulse to valid fifo_buf_out (1..4)
//  SNOOP_MAX_STREAK  4  max consecutive snoop grants while proc pop pending (1..15)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  rst             in   1       asynchronous active-high reset
//  proc_wr_req     in   1       level push request, held until proc_wr_ack
//  proc_wr_data    in   DATA_W  push data, stable while proc_wr_req=1
//  proc_wr_ack     out  1       1-cycle pulse: push issued
//  proc_rd_req     in   1       level pop request, held until proc_rd_ack
//  proc_rd_ack     out  1       1-cycle pulse: proc_rd_data valid this cycle
//  proc_rd_data    out  DATA_W  popped entry, held until next proc ack
//  snoop_rd_req    in   1       level pop request, held until snoop_rd_ack
//  snoop_rd_ack    out  1       1-cycle pulse: snoop_rd_data valid
//  snoop_rd_data   out  DATA_W  popped entry, held until next snoop ack
//  fifo_wr_en      out  1       push pulse to FIFO
//  fifo_data_in    out  DATA_W  push data to FIFO
//  fifo_rd_en      out  1       pop pulse to FIFO
//  fifo_buf_out    in   DATA_W  FIFO read data
//  fifo_buf_empty  in   1       FIFO empty flag
//  fifo_buf_full   in   1       FIFO full flag
//  rd_busy         out  1       1 when read FSM not in IDLE
// BEHAVIOUR
//  - Reset (async): all outputs 0; FSM=IDLE; streak=0; wr_block=0. In-flight pop data is discarded;
//    requesters re-request after reset.
//  - Write path, independent of read FSM:
//    - Fires when proc_wr_req & !fifo_buf_full & !wr_block.
//    - Then fifo_wr_en=1, fifo_data_in=proc_wr_data and proc_wr_ack=1 in the same cycle.
//    - wr_block=1 for exactly the next cycle, so a req still held is not pushed twice.
//    - Full: stalls, no ack, until full drops.
//  - Read FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//    - IDLE: if !fifo_buf_empty and any pop req, register grant.
//      - Snoop wins unless proc_rd_req & streak==SNOOP_MAX_STREAK.
//      - Then go to ISSUE.
//    - ISSUE: fifo_rd_en=1 for 1 cycle; load lat_cnt=READ_LAT-1; go to WAIT.
//    - WAIT: decrement lat_cnt; at 0 capture fifo_buf_out into the granted requester's data reg;
//      go to DONE.
//    - DONE: assert the granted requester's ack for 1 cycle; return to IDLE.
//    - Pop latency req->ack = READ_LAT+3 cycles minimum; back-to-back pops every READ_LAT+3 cycles.
//  - Streak counter (4-bit):
//    - +1 on snoop grant while proc_rd_req=1.
//    - Cleared on proc grant, or in any IDLE cycle with proc_rd_req=0.
//    - Saturates at SNOOP_MAX_STREAK.
//  - Empty: no pop issued; reqs wait, no ack; no underflow pulse ever reaches FIFO.
//  - Simultaneous push+pop: allowed in the same cycle (FIFO handles wr&rd). Empty is sampled before
//    the push, so a pop into an empty FIFO waits 1 cycle.
//  - Req dropped before ack: illegal; grant completes anyway and the ack is still pulsed.
//  - fifo_wr_en and fifo_rd_en are each pulses of width 1, never held.
// CONFIGURATION
//  - FIFO_ARB_STATS_EN defined: adds outputs stat_proc_pops, stat_snoop_pops, stat_pushes,
//    stat_full_stalls (each 16-bit).
//    - Each increments on its ack or on a full-stall cycle.
//    - Each saturates at 16'hFFFF; cleared by rst.
//  - Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. rst mid-WAIT (snoop pop in flight) -> all outputs 0 next sample; no snoop_rd_ack;
//     FSM IDLE; rd_busy=0.
//  2. Push 4'hA then proc pop, READ_LAT=1 -> one fifo_wr_en pulse.
//     - Then fifo_rd_en 1 cycle; proc_rd_ack 4 cycles after req; proc_rd_data=4'hA.
//  3. Both pop reqs held, FIFO holds 10 entries, SNOOP_MAX_STREAK=4 -> grant order
//     S,S,S,S,P,S,S,S,S,P.
//  4. fifo_buf_full=1 with proc_wr_req held 5 cycles -> no fifo_wr_en, no ack.
//     - Full drops -> exactly one push+ack; the held req is not pushed twice.
//  5. Empty FIFO, snoop_rd_req held, push 4'h3 -> pop issued only after empty=0.
//     - snoop_rd_data=4'h3; exactly one fifo_rd_en.
//  6. READ_LAT=3 -> fifo_buf_out sampled exactly 3 cycles after fifo_rd_en; ack 1 cycle later.

Source files
------------

// File: rtl/fifo_access_arbiter_if.sv
// Bundle of the requester-side and FIFO-side signals of the FIFO access arbiter.
// The slave modport is the arbiter's view; master is the requesters' and FIFO's view.
interface fifo_access_arbiter_if #(
    parameter int DATA_W = 4
);
    logic              proc_wr_req;
    logic [DATA_W-1:0] proc_wr_data;
    logic              proc_wr_ack;
    logic              proc_rd_req;
    logic              proc_rd_ack;
    logic [DATA_W-1:0] proc_rd_data;
    logic              snoop_rd_req;
    logic              snoop_rd_ack;
    logic [DATA_W-1:0] snoop_rd_data;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_data_in;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_buf_out;
    logic              fifo_buf_empty;
    logic              fifo_buf_full;
    logic              rd_busy;

    modport slave (
        input  proc_wr_req, proc_wr_data, proc_rd_req, snoop_rd_req,
               fifo_buf_out, fifo_buf_empty, fifo_buf_full,
        output proc_wr_ack, proc_rd_ack, proc_rd_data, snoop_rd_ack, snoop_rd_data,
               fifo_wr_en, fifo_data_in, fifo_rd_en, rd_busy
    );

    modport master (
        output proc_wr_req, proc_wr_data, proc_rd_req, snoop_rd_req,
               fifo_buf_out, fifo_buf_empty, fifo_buf_full,
        input  proc_wr_ack, proc_rd_ack, proc_rd_data, snoop_rd_ack, snoop_rd_data,
               fifo_wr_en, fifo_data_in, fifo_rd_en, rd_busy
    );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Serialises processor push, processor pop and snoop pop onto one shared FIFO.
// Define FIFO_ARB_STATS_EN to add saturating 16-bit activity counters.
module fifo_access_arbiter #(
    parameter int DATA_W           = 4,
    parameter int READ_LAT         = 1,
    parameter int SNOOP_MAX_STREAK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_access_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]            stat_proc_pops_o,
    output logic [15:0]            stat_snoop_pops_o,
    output logic [15:0]            stat_pushes_o,
    output logic [15:0]            stat_full_stalls_o
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} rd_state_e;

    localparam logic [3:0] STREAK_MAX = 4'(SNOOP_MAX_STREAK);
    localparam logic [2:0] LAT_LOAD   = 3'(READ_LAT - 1);

    rd_state_e         state_q;
    logic [2:0]        lat_cnt_q;
    logic [3:0]        streak_q, streak_d;
    logic              grant_snoop_q;
    logic              rd_en_q, proc_ack_q, snoop_ack_q;
    logic [DATA_W-1:0] proc_data_q, snoop_data_q;
    logic              wr_en_q, wr_ack_q, wr_block_q;
    logic [DATA_W-1:0] wr_data_q;

    logic wr_fire, grant_go, snoop_wins;

    assign wr_fire    = bus.proc_wr_req & ~bus.fifo_buf_full & ~wr_block_q;
    assign grant_go   = (bus.proc_rd_req | bus.snoop_rd_req) & ~bus.fifo_buf_empty;
    // Snoop keeps priority until it has starved a waiting processor pop STREAK_MAX times.
    assign snoop_wins = bus.snoop_rd_req & ~(bus.proc_rd_req & (streak_q == STREAK_MAX));

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!bus.proc_rd_req)
                streak_d = '0;
            else if (grant_go)
                streak_d = !snoop_wins              ? 4'd0 :
                           (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
    end

    // wr_block masks the cycle in which the requester is still seeing its ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_block_q <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q    <= wr_fire;
            wr_ack_q   <= wr_fire;
            wr_block_q <= wr_fire;
            if (wr_fire)
                wr_data_q <= bus.proc_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            streak_q      <= '0;
            grant_snoop_q <= 1'b0;
            rd_en_q       <= 1'b0;
            proc_ack_q    <= 1'b0;
            snoop_ack_q   <= 1'b0;
            proc_data_q   <= '0;
            snoop_data_q  <= '0;
        end else begin
            rd_en_q     <= 1'b0;
            proc_ack_q  <= 1'b0;
            snoop_ack_q <= 1'b0;
            streak_q    <= streak_d;
            case (state_q)
                IDLE: if (grant_go) begin
                    grant_snoop_q <= snoop_wins;
                    rd_en_q       <= 1'b1;
                    state_q       <= ISSUE;
                end
                ISSUE: begin
                    lat_cnt_q <= LAT_LOAD;
                    state_q   <= WAIT;
                end
                WAIT: if (lat_cnt_q == 3'd0) begin
                    if (grant_snoop_q) snoop_data_q <= bus.fifo_buf_out;
                    else               proc_data_q  <= bus.fifo_buf_out;
                    state_q <= DONE;
                end else begin
                    lat_cnt_q <= lat_cnt_q - 3'd1;
                end
                DONE: begin
                    if (grant_snoop_q) snoop_ack_q <= 1'b1;
                    else               proc_ack_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_wr_en    = wr_en_q;
    assign bus.fifo_data_in  = wr_data_q;
    assign bus.proc_wr_ack   = wr_ack_q;
    assign bus.fifo_rd_en    = rd_en_q;
    assign bus.proc_rd_ack   = proc_ack_q;
    assign bus.proc_rd_data  = proc_data_q;
    assign bus.snoop_rd_ack  = snoop_ack_q;
    assign bus.snoop_rd_data = snoop_data_q;
    assign bus.rd_busy       = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic [15:0] st_pp_q, st_sp_q, st_pu_q, st_fs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_pp_q <= '0;
            st_sp_q <= '0;
            st_pu_q <= '0;
            st_fs_q <= '0;
        end else begin
            st_pp_q <= sat_inc(st_pp_q, proc_ack_q);
            st_sp_q <= sat_inc(st_sp_q, snoop_ack_q);
            st_pu_q <= sat_inc(st_pu_q, wr_ack_q);
            st_fs_q <= sat_inc(st_fs_q, bus.proc_wr_req & bus.fifo_buf_full);
        end
    end

    assign stat_proc_pops_o   = st_pp_q;
    assign stat_snoop_pops_o  = st_sp_q;
    assign stat_pushes_o      = st_pu_q;
    assign stat_full_stalls_o = st_fs_q;
`endif
endmodule
